// File: rtl/lfsr_rand_arbiter_pkg.sv
// Shared types and helpers for the LFSR random-word arbiter.
package rand_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic [1:0] {
        ST_SEED    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_GRANT   = 2'd3
    } rand_arb_state_t;

    // Round-robin search starting one past the last winner; n is the live requester count.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int         winner;
        logic       found;
        logic [4:0] idx;
        winner = ptr;
        found  = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = 5'((ptr + i) % n);
            if ((i <= n) && !found && req[idx]) begin
                winner = int'(idx);
                found  = 1'b1;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/lfsr_rand_arbiter_lfsr.sv
// XNOR-feedback Fibonacci LFSR with seed load and a seed-match flag.
module lfsr #(
    parameter int NUM_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_LFSR_Done
);

    // Maximal-length tap masks; an odd number of XNORs keeps all-ones as the lock-up state.
    function automatic logic [31:0] taps(input int n);
        case (n)
            3:  return 32'h0000_0006;
            4:  return 32'h0000_000C;
            5:  return 32'h0000_0014;
            6:  return 32'h0000_0030;
            7:  return 32'h0000_0060;
            8:  return 32'h0000_00B8;
            9:  return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0829;
            13: return 32'h0000_100D;
            14: return 32'h0000_2015;
            15: return 32'h0000_6000;
            16: return 32'h0000_D008;
            17: return 32'h0001_2000;
            18: return 32'h0002_0400;
            19: return 32'h0004_0023;
            20: return 32'h0009_0000;
            21: return 32'h0014_0000;
            22: return 32'h0030_0000;
            23: return 32'h0042_0000;
            24: return 32'h00E1_0000;
            25: return 32'h0120_0000;
            26: return 32'h0200_0023;
            27: return 32'h0400_0013;
            28: return 32'h0900_0000;
            29: return 32'h1400_0000;
            30: return 32'h2000_0029;
            31: return 32'h4800_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

    localparam logic [NUM_BITS-1:0] TAP_MASK = NUM_BITS'(taps(NUM_BITS));

    logic [NUM_BITS-1:0] lfsr_q;
    logic [NUM_BITS-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_Enable) begin
            if (i_Seed_DV) lfsr_d = i_Seed_Data;
            else           lfsr_d = {lfsr_q[NUM_BITS-2:0], ~^(lfsr_q & TAP_MASK)};
        end
    end

    always_ff @(posedge i_Clk) begin
        lfsr_q <= lfsr_d;
    end

    assign o_LFSR_Data = lfsr_q;
    assign o_LFSR_Done = (lfsr_q == i_Seed_Data);

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter handing out LFSR words, advancing the shared LFSR STEPS shifts per grant.
module lfsr_rand_arbiter
    import rand_arb_pkg::*;
#(
    parameter int                  NUM_REQ  = 4,
    parameter int                  NUM_BITS = 16,
    parameter int                  STEPS    = NUM_BITS,
    parameter logic [NUM_BITS-1:0] SEED     = '0
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic [NUM_REQ-1:0]  i_Req,
    output logic [NUM_REQ-1:0]  o_Ack,
    output logic [NUM_BITS-1:0] o_Data,
    input  logic                i_Reseed,
    input  logic [NUM_BITS-1:0] i_Seed,
    output logic                o_Busy,
    output logic                o_Wrap
);

    localparam int              PTR_W    = $clog2(NUM_REQ);
    localparam int              CNT_W    = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);

    rand_arb_state_t     state_q, state_d;
    logic [NUM_BITS-1:0] seed_q, seed_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic                wrap_q, wrap_d;

    logic                lfsr_en, lfsr_dv, lfsr_done;
    logic [NUM_BITS-1:0] lfsr_data;
    logic [MAX_REQ-1:0]  req_ext;

    assign req_ext = MAX_REQ'(i_Req);

    lfsr #(.NUM_BITS(NUM_BITS)) u_lfsr (
        .i_Clk       (i_Clk),
        .i_Enable    (lfsr_en),
        .i_Seed_DV   (lfsr_dv),
        .i_Seed_Data (seed_q),
        .o_LFSR_Data (lfsr_data),
        .o_LFSR_Done (lfsr_done)
    );

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        data_d  = data_q;
        lfsr_en = 1'b0;
        lfsr_dv = 1'b0;
        // Only cycles that follow a shift see a post-shift LFSR value.
        wrap_d  = (((state_q == ST_ADVANCE) && (cnt_q != CNT_LOAD)) || (state_q == ST_GRANT))
                  && lfsr_done;
        case (state_q)
            ST_SEED: begin
                lfsr_en = 1'b1;
                lfsr_dv = 1'b1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_Reseed) begin
                    seed_d  = (i_Seed == '1) ? SEED : i_Seed;
                    state_d = ST_SEED;
                end else if (|i_Req) begin
                    win_d   = PTR_W'(rr_pick(req_ext, int'(ptr_q), NUM_REQ));
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                lfsr_en = 1'b1;
                if (cnt_q == '0) state_d = ST_GRANT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_GRANT: begin
                data_d       = lfsr_data;
                ack_d[win_q] = 1'b1;
                ptr_d        = win_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_SEED;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_SEED;
            seed_q  <= SEED;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_Ack  = ack_q;
    assign o_Data = data_q;
    assign o_Wrap = wrap_q;
    assign o_Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Directed bench for lfsr_rand_arbiter with NUM_REQ=2, NUM_BITS=4, STEPS=4, SEED=0.
module tb_lfsr_rand_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] ack;
    logic [3:0] data;
    logic       reseed;
    logic [3:0] seed;
    logic       busy;
    logic       wrap;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_rand_arbiter #(
        .NUM_REQ  (2),
        .NUM_BITS (4),
        .STEPS    (4),
        .SEED     (4'h0)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_n  (rst_n),
        .i_Req    (req),
        .o_Ack    (ack),
        .o_Data   (data),
        .i_Reseed (reseed),
        .i_Seed   (seed),
        .o_Busy   (busy),
        .o_Wrap   (wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps whole cycles until an acknowledge shows, counting wrap pulses on the way.
    task automatic wait_ack(input int max_cyc, output logic [1:0] a, output logic [3:0] d,
                            output int cyc, output int wraps);
        a = '0; d = '0; cyc = 0; wraps = 0;
        while (cyc < max_cyc) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (wrap) wraps++;
            if (ack != 2'b00) begin
                a = ack;
                d = data;
                break;
            end
        end
    endtask

    logic [1:0] a;
    logic [3:0] d;
    int         cyc;
    int         wr;

    initial begin
        rst_n = 1'b0; req = '0; reseed = 1'b0; seed = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack",  32'(ack),  32'h0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);

        // Single requester held: E, C, A, then 1 with the wrap inside the 4th grant.
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        req = 2'b01;
        wait_ack(20, a, d, cyc, wr);
        check("g1_ack", 32'(a), 32'h1);
        check("g1_data", 32'(d), 32'hE);
        check("g1_lat", 32'(cyc), 32'd6);
        check("g1_wrap", 32'(wr), 32'd0);
        wait_ack(20, a, d, cyc, wr);
        check("g2_ack", 32'(a), 32'h1);
        check("g2_data", 32'(d), 32'hC);
        check("g2_period", 32'(cyc), 32'd6);
        check("g2_wrap", 32'(wr), 32'd0);
        wait_ack(20, a, d, cyc, wr);
        check("g3_data", 32'(d), 32'hA);
        check("g3_wrap", 32'(wr), 32'd0);
        wait_ack(20, a, d, cyc, wr);
        check("g4_data", 32'(d), 32'h1);
        check("g4_wrap", 32'(wr), 32'd1);
        req = 2'b00;
        @(posedge clk); @(negedge clk);
        check("hold_ack", 32'(ack), 32'h0);
        check("hold_data", 32'(data), 32'h1);
        check("hold_wrap", 32'(wrap), 32'h0);

        // Reset in the middle of ADVANCE.
        req = 2'b01;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("adv_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack), 32'h0);
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_wrap", 32'(wrap), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("no_pending_ack", 32'(ack), 32'h0);

        // Both requesting after release: alternate starting at requester 0.
        req = 2'b11;
        rst_n = 1'b1;
        wait_ack(20, a, d, cyc, wr);
        check("rr1_ack", 32'(a), 32'h1);
        check("rr1_data", 32'(d), 32'hE);
        check("rr1_lat", 32'(cyc), 32'd7);
        wait_ack(20, a, d, cyc, wr);
        check("rr2_ack", 32'(a), 32'h2);
        check("rr2_data", 32'(d), 32'hC);
        wait_ack(20, a, d, cyc, wr);
        check("rr3_ack", 32'(a), 32'h1);
        check("rr3_data", 32'(d), 32'hA);
        wait_ack(20, a, d, cyc, wr);
        check("rr4_ack", 32'(a), 32'h2);
        check("rr4_data", 32'(d), 32'h1);

        // Illegal all-ones seed falls back to SEED.
        req = 2'b00; reseed = 1'b1; seed = 4'hF;
        @(posedge clk); @(negedge clk);
        reseed = 1'b0;
        check("reseed_busy", 32'(busy), 32'h1);
        @(posedge clk); @(negedge clk);
        check("reseed_idle", 32'(busy), 32'h0);
        req = 2'b10;
        wait_ack(20, a, d, cyc, wr);
        check("fb_ack", 32'(a), 32'h2);
        check("fb_data", 32'(d), 32'hE);
        check("fb_lat", 32'(cyc), 32'd6);

        // Request and reseed together: reseed first, legal seed 7 gives 6.
        req = 2'b01; reseed = 1'b1; seed = 4'h7;
        @(posedge clk); @(negedge clk);
        reseed = 1'b0;
        check("both_busy", 32'(busy), 32'h1);
        wait_ack(20, a, d, cyc, wr);
        check("both_ack", 32'(a), 32'h1);
        check("both_data", 32'(d), 32'h6);
        check("both_lat", 32'(cyc + 1), 32'd8);

        // Request dropped during ADVANCE is still acknowledged.
        req = 2'b10;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        req = 2'b00;
        wait_ack(20, a, d, cyc, wr);
        check("drop_ack", 32'(a), 32'h2);
        check("drop_data", 32'(d), 32'h5);
        check("drop_lat", 32'(cyc + 2), 32'd6);
        @(posedge clk); @(negedge clk);
        check("drop_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
